// File: rtl/bnn_seq_sched.sv
// Sequencer for the serial two-layer BNN datapath: latches a feature vector, walks hidden then class neurons,
// collects hidden bits, tracks the class argmax. Define BNN_SCHED_PERF_EN to add infer_cnt/cyc_cnt counters.
module bnn_seq_sched #(
  parameter int unsigned FEAT_CNT   = 12,
  parameter int unsigned FEAT_BITS  = 4,
  parameter int unsigned HIDDEN_CNT = 40,
  parameter int unsigned CLASS_CNT  = 6,
  localparam int unsigned FEAT_W  = FEAT_CNT * FEAT_BITS,
  localparam int unsigned SCORE_W = $clog2(HIDDEN_CNT + 1),
  localparam int unsigned IDX_W   = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1,
  localparam int unsigned PRED_W  = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FEAT_W-1:0]     features,
  output logic [FEAT_W-1:0]     feat_q,
  output logic                  layer_sel,
  output logic [IDX_W-1:0]      neuron_idx,
  output logic [HIDDEN_CNT-1:0] hidden_q,
  input  logic                  dp_act,
  input  logic [SCORE_W-1:0]    dp_score,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PRED_W-1:0]     prediction,
`ifdef BNN_SCHED_PERF_EN
  output logic [31:0]           infer_cnt,
  output logic [31:0]           cyc_cnt,
`endif
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, L0, L1, DONE} state_e;

  state_e             state_q;
  logic [SCORE_W-1:0] best_q;

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      layer_sel  <= 1'b0;
      neuron_idx <= '0;
      hidden_q   <= '0;
      prediction <= '0;
      feat_q     <= '0;
      best_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            feat_q     <= features;
            neuron_idx <= '0;
            hidden_q   <= '0;
            layer_sel  <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state_q    <= L0;
          end
        end
        L0: begin
          hidden_q[neuron_idx] <= dp_act;
          if (neuron_idx == IDX_W'(HIDDEN_CNT - 1)) begin
            neuron_idx <= '0;
            layer_sel  <= 1'b1;
            state_q    <= L1;
          end else begin
            neuron_idx <= neuron_idx + IDX_W'(1);
          end
        end
        L1: begin
          // Class 0 seeds the running max; later classes replace it only on a strict win.
          if ((neuron_idx == '0) || (dp_score > best_q)) begin
            best_q     <= dp_score;
            prediction <= PRED_W'(neuron_idx);
          end
          if (neuron_idx == IDX_W'(CLASS_CNT - 1)) begin
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state_q   <= DONE;
          end else begin
            neuron_idx <= neuron_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            layer_sel <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BNN_SCHED_PERF_EN
  // Completed output handshakes and busy cycles; both wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      infer_cnt <= '0;
      cyc_cnt   <= '0;
    end else begin
      if ((state_q == DONE) && out_valid && out_ready) infer_cnt <= infer_cnt + 32'd1;
      if (busy) cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bnn_seq_sched.sv
// Scoreboard bench for bnn_seq_sched: stimulus pushes expected results, a negedge monitor pops and compares.
// Build with BNN_SCHED_PERF_EN defined to also check the performance counters.
module tb_bnn_seq_sched;
  localparam int H = 40, C = 6, FW = 48, SW = 6, IW = 6, PW = 3, LAT = H + C;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, layer_sel, dp_act, out_valid, out_ready, busy;
  logic [FW-1:0] features, feat_q;
  logic [IW-1:0] neuron_idx;
  logic [H-1:0]  hidden_q;
  logic [SW-1:0] dp_score;
  logic [PW-1:0] prediction;
`ifdef BNN_SCHED_PERF_EN
  logic [31:0]   infer_cnt, cyc_cnt;
`endif

  bnn_seq_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .features(features),
    .feat_q(feat_q), .layer_sel(layer_sel), .neuron_idx(neuron_idx), .hidden_q(hidden_q),
    .dp_act(dp_act), .dp_score(dp_score), .out_valid(out_valid), .out_ready(out_ready),
    .prediction(prediction),
`ifdef BNN_SCHED_PERF_EN
    .infer_cnt(infer_cnt), .cyc_cnt(cyc_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: per-inference tables indexed by the presented neuron.
  logic          act_tab   [H];
  logic [SW-1:0] score_tab [C];
  always_comb begin
    dp_act   = 1'b0;
    dp_score = '0;
    if (int'(neuron_idx) < H) dp_act = act_tab[neuron_idx];
    if (layer_sel && int'(neuron_idx) < C) dp_score = score_tab[neuron_idx[2:0]];
  end

  typedef struct {
    logic [PW-1:0] pred;
    logic [H-1:0]  hid;
    logic [FW-1:0] feat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errs = 0, chks = 0, cyc = 0, acc_cyc = 0, n_done = 0;
  bit   ov_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    chks++;
    errs++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [FW-1:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[FW-1:0];
  endfunction

  // Reference: hidden bits are the activation table; prediction is the first index holding the max score.
  function automatic exp_t model(input logic [FW-1:0] f);
    exp_t e;
    int   mx, first;
    e.feat = f;
    for (int i = 0; i < H; i++) e.hid[i] = act_tab[i];
    mx = 0;
    for (int i = 0; i < C; i++) if (int'(score_tab[i]) > mx) mx = int'(score_tab[i]);
    first = -1;
    for (int i = C - 1; i >= 0; i--) if (int'(score_tab[i]) == mx) first = i;
    e.pred = PW'(first);
    return e;
  endfunction

  task automatic rand_tables();
    bit tie_mode;
    tie_mode = 1'($urandom_range(0, 1));
    for (int i = 0; i < H; i++) act_tab[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < C; i++)
      score_tab[i] = tie_mode ? SW'($urandom_range(0, 2)) : SW'($urandom_range(0, H));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: latency on the out_valid rise, payload on each output handshake.
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc + 1;
      if (out_valid && !ov_prev) begin
        chk("latency", 64'(cyc - acc_cyc), 64'(LAT));
        if (sb.size() == 0) fail_now("spurious_out_valid");
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("prediction", 64'(prediction), 64'(mon_e.pred));
        chk("hidden_q", 64'(hidden_q), 64'(mon_e.hid));
        chk("feat_q", 64'(feat_q), 64'(mon_e.feat));
        n_done++;
      end
      ov_prev = out_valid;
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  // One inference; tables must be set by the caller. hold_lo stalls out_ready in DONE.
  task automatic run_infer(input logic [FW-1:0] f, input int hold_lo, input bit rdy_early);
    bit            ok;
    logic [PW-1:0] p0;
    logic [H-1:0]  h0;
    wait_idle(ok);
    if (!ok) return;
    sb.push_back(model(f));
    features  = f;
    in_valid  = 1'b1;
    out_ready = rdy_early;
    @(posedge clk);
    #1;
    chk("busy_after_accept", 64'(busy), 64'(1));
    chk("in_ready_after_accept", 64'(in_ready), 64'(0));
    repeat (3) begin
      features = rnd48();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("out_valid_timeout");
      out_ready = 1'b0;
      return;
    end
    p0 = prediction;
    h0 = hidden_q;
    if (!rdy_early) begin
      for (int k = 0; k < hold_lo; k++) begin
        @(posedge clk);
        #1;
        in_valid = k[0];
        features = rnd48();
        @(negedge clk);
        chk("stall_out_valid", 64'(out_valid), 64'(1));
        chk("stall_prediction", 64'(prediction), 64'(p0));
        chk("stall_hidden", 64'(hidden_q), 64'(h0));
        chk("stall_in_ready", 64'(in_ready), 64'(0));
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after_hs", 64'(in_ready), 64'(1));
    chk("out_valid_after_hs", 64'(out_valid), 64'(0));
  endtask

  // Reset in the middle of L0 at neuron 17; the inference must vanish without an output.
  task automatic run_abort();
    bit ok;
    for (int i = 0; i < H; i++) act_tab[i] = 1'b1;
    wait_idle(ok);
    if (!ok) return;
    sb.push_back(model(rnd48()));
    features = sb[sb.size()-1].feat;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (busy && !layer_sel && neuron_idx == IW'(17)) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) fail_now("reach_idx17");
    chk("hidden_partial", 64'(hidden_q), (64'(1) << 17) - 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    n_done = 0;
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_hidden", 64'(hidden_q), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_neuron_idx", 64'(neuron_idx), 64'(0));
    chk("abort_feat_q", 64'(feat_q), 64'(0));
`ifdef BNN_SCHED_PERF_EN
    chk("abort_infer_cnt", 64'(infer_cnt), 64'(0));
`endif
    repeat (60) @(negedge clk);
  endtask

  task automatic perf_check(input string tag);
`ifdef BNN_SCHED_PERF_EN
    chk({tag, "_infer_cnt"}, 64'(infer_cnt), 64'(n_done));
    chk({tag, "_cyc_cnt"}, 64'(cyc_cnt), 64'(n_done * LAT));
`else
    if (tag.len() == 0) $display("perf counters absent");
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    features = '0;
    for (int i = 0; i < H; i++) act_tab[i] = 1'b0;
    for (int i = 0; i < C; i++) score_tab[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_prediction", 64'(prediction), 64'(0));
    chk("rst_hidden", 64'(hidden_q), 64'(0));
    chk("rst_feat_q", 64'(feat_q), 64'(0));
    chk("rst_layer_sel", 64'(layer_sel), 64'(0));
    perf_check("rst");

    // Alternating activations, class 3 wins.
    for (int i = 0; i < H; i++) act_tab[i] = 1'(i % 2);
    for (int i = 0; i < C; i++) score_tab[i] = (i == 3) ? SW'(30) : SW'(10);
    run_infer(rnd48(), 0, 1'b1);
    // All tied: lowest index wins.
    for (int i = 0; i < C; i++) score_tab[i] = SW'(20);
    run_infer(rnd48(), 3, 1'b0);
    // Only the last class scores.
    for (int i = 0; i < C; i++) score_tab[i] = (i == C - 1) ? SW'(40) : SW'(0);
    run_infer(rnd48(), 0, 1'b0);
    // Ten-cycle consumer stall with ignored in_valid pulses.
    rand_tables();
    run_infer(rnd48(), 10, 1'b0);

    run_abort();
    repeat (3) begin
      rand_tables();
      run_infer(rnd48(), int'($urandom_range(0, 4)), 1'b0);
    end
    perf_check("three");

    repeat (20) begin
      rand_tables();
      run_infer(rnd48(), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    perf_check("final");

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
